im2col_addr_sched: RTL and testbench
====================================

Name: im2col_addr_sched

Overview:
Sequences the im2col feature-map fetch for one convolution layer.
- Starts when `start_conv` from the conv control unit rises. Takes the layer config from that unit (tensor_size, kernel_size, channels, stride).
- Computes the output feature size and reports it back as `n_ofs` / `n_para_done`. This lets the next layer's config be derived.
- Streams feature-buffer read addresses in im2col order over a valid/ready handshake. Pulses `w_done` when the whole layer has been issued.

Parameters:
ADDR_W, 16, width of the feature-buffer read address.
CNT_W, 16, width of the optional stall counter.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start_conv  in  1  level from control unit; rising edge starts a layer; held until w_done
tensor_size  in  `TENSOR_SIZE  input width/height T (square)
kernel_size  in  `KERNEL_SIZE  kernel width/height K
channels  in  `CHANNELS_SIZE  input channels C
stride  in  `STRIDE_SIZE  stride S (0 treated as 1)
addr  out  ADDR_W  feature read address
addr_valid  out  1  addr valid
addr_ready  in  1  consumer accepts addr
row_last  out  1  with addr_valid: last address of one im2col row (window)
n_ofs  out  `TENSOR_SIZE  output size minus 1 (last window index)
n_para_done  out  1  one-cycle pulse when n_ofs is valid
w_done  out  1  one-cycle pulse after the last address is accepted
cfg_err  out  1  one-cycle pulse when K>T, K=0 or C=0
stall_cnt  out  CNT_W  present only with the optional feature

Behaviour:
- Reset values: all outputs 0, state IDLE.
- Reset is honoured mid-operation: the layer is aborted and no w_done is issued.
- `start_conv` is registered; a rise (prev 0, now 1) in IDLE is the start event. Config inputs are latched on that cycle, and later changes are ignored until the next start.
- State IDLE -> CALC on the start event.
- CALC computes the output size without a divider:
  - x starts at 0 and the count at 0.
  - Each cycle: if x+K<=T, then count++ and x+=S; otherwise leave CALC.
  - Takes ofs+1 cycles.
  - On exit with count>0: n_ofs<=count-1, pulse n_para_done, go to GEN.
  - If count==0, K==0 or C==0: pulse cfg_err and w_done together, return to IDLE. No addresses are issued.
- GEN uses nested counters, outermost first: oy, ox (0..n_ofs), c (0..C-1), ky, kx (0..K-1).
  - addr = c*T*T + (oy*S+ky)*T + ox*S + kx.
  - The address is built from incrementally accumulated bases (adders only, no multipliers in the address path). It is truncated to ADDR_W.
  - addr, row_last and addr_valid are registered outputs. A transfer happens when addr_valid && addr_ready.
  - While addr_valid && !addr_ready, addr and row_last hold stable.
  - Back-to-back transfers run at 1 address/cycle.
  - row_last = (c==C-1 && ky==K-1 && kx==K-1).
- After the final transfer (all counters at their max): addr_valid<=0, w_done pulses the next cycle, go to DONE.
- DONE -> IDLE when start_conv==0. A start edge is never accepted outside IDLE.
- A start edge that coincides with reset release is ignored.

Optional Feature:
IM2COL_STALL_CNT_EN
- Defined: stall_cnt counts cycles in GEN with addr_valid && !addr_ready. It clears on the start event, saturates at all-ones, and holds its value after w_done.
- Undefined: the stall_cnt port and its logic are absent.

Decomposition:
- Shared package/config: width macros `TENSOR_SIZE`, `KERNEL_SIZE`, `CHANNELS_SIZE`, `STRIDE_SIZE`; state encoding constants IDLE/CALC/GEN/DONE (one-hot).
- One natural sub-module: `im2col_win_cnt`. It holds the kx/ky/c nested counters, with inputs step and clear, and outputs wrap flags and the incremental partial address. The top module owns the FSM, oy/ox, and the handshake.

Test Plan:
- T=5, K=3, S=1, C=1, ready always 1 -> n_para_done with n_ofs=2; 81 addresses. First window is 0,1,2,5,6,7,10,11,12 with row_last on 12. Last address is 24. w_done pulses once.
- T=6, K=3, S=2, C=2 -> n_ofs=1; 4 windows x 18 = 72 addresses. Second window starts at 2; channel-1 part of window 0 starts at 36.
- Same as case 1 with addr_ready toggling 1,0,0,1 -> addr is stable during stalls; total transfers still 81; with IM2COL_STALL_CNT_EN, stall_cnt equals the number of stalled cycles.
- K=7, T=5 -> cfg_err and w_done pulse in the same cycle; addr_valid never asserts; returns to IDLE.
- rstn asserted mid-GEN with start_conv held high -> all outputs 0 immediately; no w_done; after release, no restart until start_conv falls and rises again.
- start_conv held high through DONE -> no second layer; a 0-then-1 on start_conv starts the next layer.

Source files
------------

// File: rtl/im2col_addr_sched_pkg.sv
// -----------------------------------------------------------------------------
// im2col_addr_sched_pkg
// Shared configuration for the im2col address scheduler.
//   - Width macros for the layer configuration fields (overridable on the
//     command line): TENSOR_SIZE, KERNEL_SIZE, CHANNELS_SIZE, STRIDE_SIZE.
//   - One-hot state encoding for the scheduler FSM.
//   - Helper that maps a zero stride onto a stride of one.
// -----------------------------------------------------------------------------
`ifndef TENSOR_SIZE
`define TENSOR_SIZE 8
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 4
`endif
`ifndef CHANNELS_SIZE
`define CHANNELS_SIZE 8
`endif
`ifndef STRIDE_SIZE
`define STRIDE_SIZE 4
`endif

package im2col_addr_sched_pkg;

   localparam int TW  = `TENSOR_SIZE;
   localparam int KW  = `KERNEL_SIZE;
   localparam int CHW = `CHANNELS_SIZE;
   localparam int SW  = `STRIDE_SIZE;

   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      CALC = 4'b0010,
      GEN  = 4'b0100,
      DONE = 4'b1000
   } state_t;

   // A stride of zero is meaningless for a convolution; treat it as one.
   function automatic logic [SW-1:0] eff_stride(input logic [SW-1:0] s);
      logic [SW-1:0] r;
      if (s == '0) begin
         r = SW'(1'b1);
      end else begin
         r = s;
      end
      return r;
   endfunction

endpackage

// File: rtl/im2col_win_cnt.sv
// -----------------------------------------------------------------------------
// im2col_win_cnt
// Inner nested counters of one im2col window: kx (fastest), ky, c (slowest).
// The partial address c*T*T + ky*T + kx is kept as running sums so the
// address path needs adders only.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   clear          synchronous return of all counters to zero
//   step           advance to the next element of the window (wraps to 0)
//   k, c_num       kernel size K and channel count C of the layer
//   t, tt          tensor row pitch T and plane pitch T*T
//   kx_last, ky_last, c_last   current counter is at its maximum
//   part_addr      c*T*T + ky*T + kx for the current counters
// -----------------------------------------------------------------------------
module im2col_win_cnt
   import im2col_addr_sched_pkg::*;
#(
   parameter int ADDR_W = 16
)
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              clear,
   input  logic              step,
   input  logic [KW-1:0]     k,
   input  logic [CHW-1:0]    c_num,
   input  logic [ADDR_W-1:0] t,
   input  logic [ADDR_W-1:0] tt,
   output logic              kx_last,
   output logic              ky_last,
   output logic              c_last,
   output logic [ADDR_W-1:0] part_addr
);

   logic [KW-1:0]     kx_r;
   logic [KW-1:0]     ky_r;
   logic [CHW-1:0]    c_r;
   logic [ADDR_W-1:0] row_r;    // ky*T
   logic [ADDR_W-1:0] plane_r;  // c*T*T

   assign kx_last   = (kx_r == (k - KW'(1'b1)));
   assign ky_last   = (ky_r == (k - KW'(1'b1)));
   assign c_last    = (c_r == (c_num - CHW'(1'b1)));
   assign part_addr = plane_r + row_r + ADDR_W'(kx_r);

   // Nested kx/ky/c counters with their accumulated address bases.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         kx_r    <= '0;
         ky_r    <= '0;
         c_r     <= '0;
         row_r   <= '0;
         plane_r <= '0;
      end else if (clear) begin
         kx_r    <= '0;
         ky_r    <= '0;
         c_r     <= '0;
         row_r   <= '0;
         plane_r <= '0;
      end else if (step) begin
         if (kx_last) begin
            kx_r <= '0;
            if (ky_last) begin
               ky_r  <= '0;
               row_r <= '0;
               if (c_last) begin
                  c_r     <= '0;
                  plane_r <= '0;
               end else begin
                  c_r     <= c_r + CHW'(1'b1);
                  plane_r <= plane_r + tt;
               end
            end else begin
               ky_r  <= ky_r + KW'(1'b1);
               row_r <= row_r + t;
            end
         end else begin
            kx_r <= kx_r + KW'(1'b1);
         end
      end else begin
         kx_r    <= kx_r;
         ky_r    <= ky_r;
         c_r     <= c_r;
         row_r   <= row_r;
         plane_r <= plane_r;
      end
   end

endmodule

// File: rtl/im2col_addr_sched.sv
// -----------------------------------------------------------------------------
// im2col_addr_sched
// Sequences the im2col feature-map fetch of one convolution layer.
// On a rising start_conv in IDLE the layer config is latched, the output size
// is found by repeated addition (CALC), then feature-buffer addresses are
// streamed in im2col order (oy, ox, c, ky, kx) over a valid/ready handshake.
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   start_conv                 level; rising edge in IDLE starts a layer
//   tensor_size, kernel_size, channels, stride   layer config (T, K, C, S)
//   addr, addr_valid, addr_ready                 address stream
//   row_last                   last address of one window
//   n_ofs, n_para_done         output size minus 1, with its valid pulse
//   w_done                     layer finished (or rejected) pulse
//   cfg_err                    rejected config pulse (K>T, K=0 or C=0)
//   stall_cnt                  only when IM2COL_STALL_CNT_EN is defined:
//                              GEN cycles with addr_valid && !addr_ready
// -----------------------------------------------------------------------------
module im2col_addr_sched
   import im2col_addr_sched_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16
)
(
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start_conv,
   input  logic [`TENSOR_SIZE-1:0]   tensor_size,
   input  logic [`KERNEL_SIZE-1:0]   kernel_size,
   input  logic [`CHANNELS_SIZE-1:0] channels,
   input  logic [`STRIDE_SIZE-1:0]   stride,
   output logic [ADDR_W-1:0]         addr,
   output logic                      addr_valid,
   input  logic                      addr_ready,
   output logic                      row_last,
   output logic [`TENSOR_SIZE-1:0]   n_ofs,
   output logic                      n_para_done,
   output logic                      w_done,
   output logic                      cfg_err
`ifdef IM2COL_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]          stall_cnt
`endif
);

   state_t            state_r;
   logic              start_r;
   logic [TW-1:0]     t_r;
   logic [KW-1:0]     k_r;
   logic [CHW-1:0]    c_r;
   logic [SW-1:0]     s_r;
   logic [ADDR_W-1:0] tt_r;       // T*T, plane pitch
   logic [ADDR_W-1:0] st_r;       // S*T, output-row pitch
   logic [TW+1:0]     x_r;        // window origin probe used by CALC
   logic [TW-1:0]     cnt_r;
   logic [TW-1:0]     oy_r;
   logic [TW-1:0]     ox_r;
   logic [ADDR_W-1:0] oy_base_r;  // oy*S*T
   logic [ADDR_W-1:0] ox_off_r;   // ox*S
   logic              more_r;     // counters still point at an unissued address

   logic              start_evt_s;
   logic              step_s;
   logic              fit_s;
   logic              kx_last_s;
   logic              ky_last_s;
   logic              c_last_s;
   logic              win_last_s;
   logic [ADDR_W-1:0] part_s;

   // Reset initialises start_r to 1 so a level already high at reset
   // release is not mistaken for a rising edge.
   assign start_evt_s = (state_r == IDLE) && start_conv && !start_r;
   // The counters always hold the next address to present; load it when the
   // output register is empty or being emptied this cycle.
   assign step_s      = (state_r == GEN) && more_r && (!addr_valid || addr_ready);
   assign fit_s       = ((x_r + (TW+2)'(k_r)) <= (TW+2)'(t_r));
   assign win_last_s  = kx_last_s && ky_last_s && c_last_s;

   im2col_win_cnt #(.ADDR_W(ADDR_W)) u_win_cnt (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (start_evt_s),
      .step      (step_s),
      .k         (k_r),
      .c_num     (c_r),
      .t         (ADDR_W'(t_r)),
      .tt        (tt_r),
      .kx_last   (kx_last_s),
      .ky_last   (ky_last_s),
      .c_last    (c_last_s),
      .part_addr (part_s)
   );

   // Scheduler FSM with config latch, output-size search and address issue.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r     <= IDLE;
         start_r     <= 1'b1;
         t_r         <= '0;
         k_r         <= '0;
         c_r         <= '0;
         s_r         <= '0;
         tt_r        <= '0;
         st_r        <= '0;
         x_r         <= '0;
         cnt_r       <= '0;
         oy_r        <= '0;
         ox_r        <= '0;
         oy_base_r   <= '0;
         ox_off_r    <= '0;
         more_r      <= 1'b0;
         addr        <= '0;
         addr_valid  <= 1'b0;
         row_last    <= 1'b0;
         n_ofs       <= '0;
         n_para_done <= 1'b0;
         w_done      <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         start_r     <= start_conv;
         n_para_done <= 1'b0;
         w_done      <= 1'b0;
         cfg_err     <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start_evt_s) begin
                  t_r       <= tensor_size;
                  k_r       <= kernel_size;
                  c_r       <= channels;
                  s_r       <= eff_stride(stride);
                  // One-time config products; the per-address path only adds.
                  tt_r      <= ADDR_W'(tensor_size) * ADDR_W'(tensor_size);
                  st_r      <= ADDR_W'(eff_stride(stride)) * ADDR_W'(tensor_size);
                  x_r       <= '0;
                  cnt_r     <= '0;
                  oy_r      <= '0;
                  ox_r      <= '0;
                  oy_base_r <= '0;
                  ox_off_r  <= '0;
                  more_r    <= 1'b1;
                  state_r   <= CALC;
               end else begin
                  state_r <= IDLE;
               end
            end
            CALC: begin
               if ((k_r == '0) || (c_r == '0)) begin
                  cfg_err <= 1'b1;
                  w_done  <= 1'b1;
                  state_r <= IDLE;
               end else if (fit_s) begin
                  cnt_r <= cnt_r + TW'(1'b1);
                  x_r   <= x_r + (TW+2)'(s_r);
               end else if (cnt_r == '0) begin
                  cfg_err <= 1'b1;
                  w_done  <= 1'b1;
                  state_r <= IDLE;
               end else begin
                  n_ofs       <= cnt_r - TW'(1'b1);
                  n_para_done <= 1'b1;
                  state_r     <= GEN;
               end
            end
            GEN: begin
               if (step_s) begin
                  addr       <= oy_base_r + ox_off_r + part_s;
                  row_last   <= win_last_s;
                  addr_valid <= 1'b1;
                  if (win_last_s) begin
                     if (ox_r == n_ofs) begin
                        ox_r     <= '0;
                        ox_off_r <= '0;
                        if (oy_r == n_ofs) begin
                           more_r <= 1'b0;
                        end else begin
                           oy_r      <= oy_r + TW'(1'b1);
                           oy_base_r <= oy_base_r + st_r;
                        end
                     end else begin
                        ox_r     <= ox_r + TW'(1'b1);
                        ox_off_r <= ox_off_r + ADDR_W'(s_r);
                     end
                  end else begin
                     ox_r <= ox_r;
                  end
               end else if (addr_valid && addr_ready) begin
                  // Final address accepted with nothing left to issue.
                  addr_valid <= 1'b0;
                  w_done     <= 1'b1;
                  state_r    <= DONE;
               end else begin
                  state_r <= GEN;
               end
            end
            DONE: begin
               if (!start_conv) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r    <= IDLE;
               addr_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef IM2COL_STALL_CNT_EN
   // Saturating count of back-pressured GEN cycles; cleared per layer.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt <= '0;
      end else if (start_evt_s) begin
         stall_cnt <= '0;
      end else if ((state_r == GEN) && addr_valid && !addr_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1'b1);
      end else begin
         stall_cnt <= stall_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_im2col_addr_sched.sv
// -----------------------------------------------------------------------------
// tb_im2col_addr_sched
// Directed bench for im2col_addr_sched. A reference model builds the
// expected address/row_last stream from the im2col formula; a monitor on the
// falling edge checks every transfer, n_ofs, w_done/cfg_err and stall
// stability against it.
// -----------------------------------------------------------------------------
`ifndef TENSOR_SIZE
`define TENSOR_SIZE 8
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 4
`endif
`ifndef CHANNELS_SIZE
`define CHANNELS_SIZE 8
`endif
`ifndef STRIDE_SIZE
`define STRIDE_SIZE 4
`endif

module tb_im2col_addr_sched;

   localparam int ADDR_W = 16;
   localparam int CNT_W  = 16;

   logic                      clk = 1'b0;
   logic                      rstn = 1'b0;
   logic                      start_conv = 1'b0;
   logic [`TENSOR_SIZE-1:0]   tensor_size = '0;
   logic [`KERNEL_SIZE-1:0]   kernel_size = '0;
   logic [`CHANNELS_SIZE-1:0] channels = '0;
   logic [`STRIDE_SIZE-1:0]   stride = '0;
   logic [ADDR_W-1:0]         addr;
   logic                      addr_valid;
   logic                      addr_ready;
   logic                      row_last;
   logic [`TENSOR_SIZE-1:0]   n_ofs;
   logic                      n_para_done;
   logic                      w_done;
   logic                      cfg_err;
`ifdef IM2COL_STALL_CNT_EN
   logic [CNT_W-1:0]          stall_cnt;
`endif

   im2col_addr_sched #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .start_conv  (start_conv),
      .tensor_size (tensor_size),
      .kernel_size (kernel_size),
      .channels    (channels),
      .stride      (stride),
      .addr        (addr),
      .addr_valid  (addr_valid),
      .addr_ready  (addr_ready),
      .row_last    (row_last),
      .n_ofs       (n_ofs),
      .n_para_done (n_para_done),
      .w_done      (w_done),
      .cfg_err     (cfg_err)
`ifdef IM2COL_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   initial forever #5 clk = ~clk;

   int   nvec = 0;
   int   nerr = 0;
   int   exp_q[$];
   bit   exp_rl[$];
   int   exp_nofs = 0;
   bit   exp_err = 1'b0;
   int   exp_total = 0;
   int   wdone_cnt = 0;
   int   npd_cnt = 0;
   int   err_cnt = 0;
   int   xfer_cnt = 0;
   int   stall_seen = 0;
   bit   stall_prev = 1'b0;
   logic [ADDR_W-1:0] prev_addr = '0;
   int   rdy_mode = 0;

   task automatic check(input string name, input longint act, input longint exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain im2col enumeration of the whole layer.
   task automatic build_model(input int t, input int k, input int c, input int s);
      int se;
      int n;
      se = (s == 0) ? 1 : s;
      exp_q.delete();
      exp_rl.delete();
      exp_err = (k == 0) || (c == 0) || (k > t);
      exp_nofs = 0;
      if (!exp_err) begin
         n = (t - k) / se + 1;
         exp_nofs = n - 1;
         for (int oy = 0; oy < n; oy++)
            for (int ox = 0; ox < n; ox++)
               for (int ch = 0; ch < c; ch++)
                  for (int ky = 0; ky < k; ky++)
                     for (int kx = 0; kx < k; kx++) begin
                        exp_q.push_back((ch*t*t + (oy*se + ky)*t + ox*se + kx) & 32'h0000FFFF);
                        exp_rl.push_back((ch == c-1) && (ky == k-1) && (kx == k-1));
                     end
      end
      exp_total = exp_q.size();
   endtask

   // Consumer ready: always 1, or the repeating pattern 1,0,0,1.
   initial begin
      int ph;
      ph = 0;
      addr_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (rdy_mode == 0) addr_ready = 1'b1;
         else addr_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
         ph++;
      end
   end

   // Monitor: compare every meaningful output against the model.
   always @(negedge clk) begin
      int e;
      bit r;
      if (!rstn) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", addr_valid, 1);
            check("hold_addr", addr, prev_addr);
         end
         if (addr_valid && addr_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
               check("xfer_count_overrun", xfer_cnt, exp_total);
            end else begin
               e = exp_q.pop_front();
               r = exp_rl.pop_front();
               check("addr", addr, e);
               check("row_last", row_last, r);
            end
         end
         stall_prev = addr_valid && !addr_ready;
         prev_addr  = addr;
         if (stall_prev) stall_seen++;
         if (n_para_done) begin
            npd_cnt++;
            check("n_ofs", n_ofs, exp_nofs);
         end
         if (w_done) begin
            wdone_cnt++;
            check("cfg_err_at_w_done", cfg_err, exp_err);
            check("pending_at_w_done", exp_q.size(), 0);
         end
         if (cfg_err) err_cnt++;
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_addr"}, addr, 0);
      check({tag, "_addr_valid"}, addr_valid, 0);
      check({tag, "_row_last"}, row_last, 0);
      check({tag, "_n_ofs"}, n_ofs, 0);
      check({tag, "_n_para_done"}, n_para_done, 0);
      check({tag, "_w_done"}, w_done, 0);
      check({tag, "_cfg_err"}, cfg_err, 0);
   endtask

   task automatic launch(input int t, input int k, input int c, input int s, input int mode);
      @(negedge clk);
      start_conv  = 1'b0;
      rdy_mode    = mode;
      tensor_size = `TENSOR_SIZE'(t);
      kernel_size = `KERNEL_SIZE'(k);
      channels    = `CHANNELS_SIZE'(c);
      stride      = `STRIDE_SIZE'(s);
      repeat (2) @(negedge clk);
      wdone_cnt = 0; npd_cnt = 0; err_cnt = 0; xfer_cnt = 0; stall_seen = 0;
      start_conv = 1'b1;
      @(negedge clk);
      // Config must be latched at the start edge; scramble it afterwards.
      tensor_size = `TENSOR_SIZE'(t + 3);
      kernel_size = `KERNEL_SIZE'(1);
      channels    = `CHANNELS_SIZE'(c + 1);
      stride      = `STRIDE_SIZE'(3);
   endtask

   task automatic run_layer(input int t, input int k, input int c, input int s,
                            input int mode, input string tag);
      int i;
      build_model(t, k, c, s);
      launch(t, k, c, s, mode);
      i = 0;
      while (wdone_cnt == 0 && i < 5000) begin
         @(negedge clk);
         i++;
      end
      check({tag, "_w_done_seen"}, wdone_cnt, 1);
      // start_conv stays high through DONE: no second layer may begin.
      repeat (20) @(negedge clk);
      check({tag, "_w_done_count"}, wdone_cnt, 1);
      check({tag, "_n_para_done_count"}, npd_cnt, exp_err ? 0 : 1);
      check({tag, "_cfg_err_count"}, err_cnt, exp_err ? 1 : 0);
      check({tag, "_transfers"}, xfer_cnt, exp_total);
      check({tag, "_valid_idle"}, addr_valid, 0);
`ifdef IM2COL_STALL_CNT_EN
      check({tag, "_stall_cnt"}, stall_cnt, stall_seen);
`endif
      start_conv = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int lit1[9];
      int i;
      lit1 = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

      // Reset state.
      repeat (2) @(negedge clk);
      check_zero("reset");
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      check("post_reset_valid", addr_valid, 0);

      // Pin the model with hand-computed values.
      build_model(5, 3, 1, 1);
      check("model1_nofs", exp_nofs, 2);
      check("model1_size", exp_q.size(), 81);
      for (int j = 0; j < 9; j++) check("model1_win0", exp_q[j], lit1[j]);
      check("model1_rl8", exp_rl[8], 1);
      check("model1_rl7", exp_rl[7], 0);
      check("model1_last", exp_q[80], 24);
      build_model(6, 3, 2, 2);
      check("model2_nofs", exp_nofs, 1);
      check("model2_size", exp_q.size(), 72);
      check("model2_ch1", exp_q[9], 36);
      check("model2_win1", exp_q[18], 2);

      run_layer(5, 3, 1, 1, 0, "t5k3");
      run_layer(6, 3, 2, 2, 0, "t6k3s2c2");
      run_layer(5, 3, 1, 1, 1, "t5k3_stall");
      run_layer(5, 7, 1, 1, 0, "k_gt_t");
      run_layer(4, 0, 1, 1, 0, "k_zero");
      run_layer(4, 1, 3, 0, 0, "stride0");
      run_layer(5, 5, 2, 1, 1, "k_eq_t");

      // Reset in the middle of GEN with start_conv held high.
      build_model(5, 3, 1, 1);
      launch(5, 3, 1, 1, 0);
      i = 0;
      while (xfer_cnt < 30 && i < 2000) begin
         @(negedge clk);
         i++;
      end
      check("midreset_progress", xfer_cnt >= 30, 1);
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check_zero("midreset");
      exp_q.delete();
      exp_rl.delete();
      exp_total = xfer_cnt;
      wdone_cnt = 0;
      npd_cnt = 0;
      @(negedge clk);
      rstn = 1'b1;
      repeat (30) @(negedge clk);
      check("midreset_no_w_done", wdone_cnt, 0);
      check("midreset_no_restart", npd_cnt, 0);
      check("midreset_valid", addr_valid, 0);

      // Falling then rising start_conv begins a fresh layer.
      run_layer(5, 3, 1, 1, 0, "after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
